// File: rtl/core_pkg.sv
// core_pkg: opcode map, FSM state encoding and flag layout shared by the
// multicycle core and its ALU.
package core_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_MOV  = 4'h1,
      OP_ADD  = 4'h2,
      OP_SUB  = 4'h3,
      OP_AND  = 4'h4,
      OP_OR   = 4'h5,
      OP_XOR  = 4'h6,
      OP_LDI  = 4'h7,
      OP_LD   = 4'h8,
      OP_ST   = 4'h9,
      OP_BZ   = 4'hA,
      OP_BN   = 4'hB,
      OP_JMP  = 4'hC,
      OP_JAL  = 4'hD,
      OP_HALT = 4'hE,
      OP_RSV  = 4'hF
   } opcode_t;

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_EXEC  = 2'd1,
      S_MEM   = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   // Packed so that it maps straight onto the {C,N,Z} flags port.
   typedef struct packed {
      logic c;
      logic n;
      logic z;
   } flags_t;

endpackage

// File: rtl/core_alu.sv
// core_alu: combinational DW-wide ALU for ADD/SUB/AND/OR/XOR with carry,
// negative and zero outputs; other opcodes yield a zero result.
module core_alu
   import core_pkg::*;
#(
   parameter int DW = 16
) (
   input  logic [3:0]    op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          c,
   output logic          n,
   output logic          z
);

   logic [DW:0] sum;

   assign sum = {1'b0, a} + {1'b0, b};

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      result = '0;
      c      = 1'b0;
      case (opcode_t'(op))
         OP_ADD: {c, result} = sum;
         OP_SUB: begin
            result = a - b;
            c      = (a >= b);
         end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         default: ;
      endcase
   end

   assign n = result[DW-1];
   assign z = (result == '0);

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: FETCH/EXEC/MEM/HALT 16-bit-instruction core with register
// file, PC and flags. Define CORE_JAL_EN to enable JAL (opcode D); else it is a NOP.
module multicycle_core
   import core_pkg::*;
#(
   parameter int DW   = 16,
   parameter int AW   = 16,
   parameter int NREG = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic          imem_ack,
   input  logic [15:0]   imem_rdata,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [AW-1:0] dmem_addr,
   output logic [DW-1:0] dmem_wdata,
   input  logic          dmem_ack,
   input  logic [DW-1:0] dmem_rdata,
   output logic [AW-1:0] pc,
   output logic          halted,
   output logic [2:0]    flags
);

   localparam int RW = $clog2(NREG);

   state_t        state, state_nxt;
   logic          running;
   logic [15:0]   ir;
   logic [DW-1:0] regs [NREG];
   logic [AW-1:0] pc_q, pc_nxt, pc_inc, pc_rel;
   flags_t        flags_q;

   opcode_t       op;
   logic [RW-1:0] dst_i, src_i;
   logic [DW-1:0] dst_val, src_val, addr_val, alu_res;
   logic          alu_c, alu_n, alu_z;

   logic          ir_we, rf_we, flags_we;
   logic [RW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;

   assign op       = opcode_t'(ir[15:12]);
   assign dst_i    = ir[8 +: RW];
   assign src_i    = ir[4 +: RW];
   assign dst_val  = regs[dst_i];
   assign src_val  = regs[src_i];
   assign addr_val = (op == OP_ST) ? dst_val : src_val;
   assign pc_inc   = pc_q + AW'(1);
   assign pc_rel   = pc_inc + AW'($signed(ir[7:0]));

   core_alu #(.DW(DW)) u_alu (
      .op     (ir[15:12]),
      .a      (dst_val),
      .b      (src_val),
      .result (alu_res),
      .c      (alu_c),
      .n      (alu_n),
      .z      (alu_z)
   );

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc_q;
      ir_we     = 1'b0;
      rf_we     = 1'b0;
      rf_waddr  = dst_i;
      rf_wdata  = alu_res;
      flags_we  = 1'b0;
      case (state)
         // The first cycle out of reset is idle, so a stale ack is never taken.
         S_FETCH: if (running && imem_ack) begin
            ir_we     = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            state_nxt = S_FETCH;
            pc_nxt    = pc_inc;
            case (op)
               OP_MOV: begin
                  rf_we    = 1'b1;
                  rf_wdata = src_val;
               end
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                  rf_we    = 1'b1;
                  flags_we = 1'b1;
               end
               OP_LDI: begin
                  rf_we    = 1'b1;
                  rf_wdata = DW'($signed(ir[7:0]));
               end
               OP_LD, OP_ST: begin
                  state_nxt = S_MEM;
                  pc_nxt    = pc_q;
               end
               OP_BZ:  if (flags_q.z) pc_nxt = pc_rel;
               OP_BN:  if (flags_q.n) pc_nxt = pc_rel;
               OP_JMP: pc_nxt = pc_rel;
`ifdef CORE_JAL_EN
               OP_JAL: begin
                  rf_we    = 1'b1;
                  rf_waddr = RW'(NREG - 1);
                  rf_wdata = DW'(pc_inc);
                  pc_nxt   = pc_rel;
               end
`endif
               OP_HALT: begin
                  state_nxt = S_HALT;
                  pc_nxt    = pc_q;
               end
               default: ;
            endcase
         end
         S_MEM: if (dmem_ack) begin
            state_nxt = S_FETCH;
            pc_nxt    = pc_inc;
            if (op == OP_LD) begin
               rf_we    = 1'b1;
               rf_wdata = dmem_rdata;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_FETCH;
         running <= 1'b0;
         pc_q    <= '0;
         flags_q <= '0;
         ir      <= '0;
      end else begin
         // NOTE: non-blocking assignments so all state samples the pre-edge values together.
         state   <= state_nxt;
         running <= 1'b1;
         pc_q    <= pc_nxt;
         if (ir_we)    ir      <= imem_rdata;
         if (flags_we) flags_q <= {alu_c, alu_n, alu_z};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the register file is a flop array, not a RAM, so every entry must be reset.
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else if (rf_we) begin
         regs[rf_waddr] <= rf_wdata;
      end
   end

   // Request strobes decode from state, so reset drops them immediately.
   assign imem_req   = (state == S_FETCH) && running;
   assign imem_addr  = pc_q;
   assign dmem_req   = (state == S_MEM);
   assign dmem_we    = dmem_req && (op == OP_ST);
   assign dmem_addr  = addr_val[AW-1:0];
   assign dmem_wdata = src_val;
   assign pc         = pc_q;
   assign halted     = (state == S_HALT);
   assign flags      = flags_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: program-driven bench for multicycle_core with an
// instruction ROM, a delayed-ack data memory and store/fetch scoreboards.
module tb_multicycle_core;

   localparam int DW = 16;
   localparam int AW = 16;

   typedef struct packed {
      logic [15:0] addr;
      logic [15:0] data;
   } st_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          imem_req, imem_ack;
   logic [AW-1:0] imem_addr;
   logic [15:0]   imem_rdata;
   logic          dmem_req, dmem_we, dmem_ack;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_wdata, dmem_rdata;
   logic [AW-1:0] pc;
   logic          halted;
   logic [2:0]    flags;

   logic [15:0] prog [0:255];
   logic [15:0] dmem [0:255];
   int          dmem_delay = 0;
   int          wait_cnt   = 0;

   int compared = 0;
   int failed   = 0;

   st_t           store_q [$];
   logic [AW-1:0] fetch_q [$];
   bit            fetch_chk = 1'b0;

   multicycle_core #(.DW(DW), .AW(AW), .NREG(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .pc         (pc),
      .halted     (halted),
      .flags      (flags)
   );

   always #5 clk = ~clk;

   assign imem_ack   = imem_req;
   assign imem_rdata = prog[imem_addr[7:0]];
   assign dmem_ack   = dmem_req && (wait_cnt >= dmem_delay);
   assign dmem_rdata = dmem[dmem_addr[7:0]];

   always @(posedge clk) begin
      if (!dmem_req || dmem_ack) wait_cnt <= 0;
      else                       wait_cnt <= wait_cnt + 1;
      if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:0]] <= dmem_wdata;
   end

   // Monitor: request exclusivity, fetch order, MEM stability/latency, stores.
   bit            in_txn = 1'b0, chk_pc = 1'b0;
   logic [AW-1:0] t_addr, t_pc, t_pc_nxt, exp_fetch;
   logic [DW-1:0] t_wdata;
   logic          t_we;
   int            t_cyc;
   st_t           exp_st;

   always @(negedge clk) begin
      if (!rst_n) begin
         in_txn = 1'b0;
         chk_pc = 1'b0;
      end else begin
         if (imem_req || dmem_req) begin
            compared++;
            if (imem_req && dmem_req) begin
               failed++;
               $display("FAIL req_exclusive: imem_req=%0b dmem_req=%0b, required not both 1", imem_req, dmem_req);
            end
         end
         if (imem_req && imem_ack && fetch_chk) begin
            compared++;
            if (fetch_q.size() == 0) begin
               failed++;
               $display("FAIL fetch_order: fetch of 0x%0h, required no further fetch", imem_addr);
            end else begin
               exp_fetch = fetch_q.pop_front();
               if (imem_addr !== exp_fetch) begin
                  failed++;
                  $display("FAIL fetch_order: got 0x%0h, required 0x%0h", imem_addr, exp_fetch);
               end
            end
         end
         if (dmem_req) begin
            if (!in_txn) begin
               in_txn  = 1'b1;
               t_addr  = dmem_addr;
               t_wdata = dmem_wdata;
               t_we    = dmem_we;
               t_pc    = pc;
               t_cyc   = 0;
            end else begin
               compared++;
               if ({dmem_addr, dmem_wdata, dmem_we, pc} !== {t_addr, t_wdata, t_we, t_pc}) begin
                  failed++;
                  $display("FAIL mem_stable: got addr=0x%0h wdata=0x%0h we=%0b pc=0x%0h, required 0x%0h 0x%0h %0b 0x%0h",
                           dmem_addr, dmem_wdata, dmem_we, pc, t_addr, t_wdata, t_we, t_pc);
               end
            end
            t_cyc++;
            if (dmem_ack) begin
               in_txn = 1'b0;
               chk_pc = 1'b1;
               compared++;
               if (t_cyc != dmem_delay + 1) begin
                  failed++;
                  $display("FAIL mem_latency: request held %0d cycles, required %0d", t_cyc, dmem_delay + 1);
               end
               if (dmem_we) begin
                  compared++;
                  if (store_q.size() == 0) begin
                     failed++;
                     $display("FAIL store: got addr=0x%0h data=0x%0h, required no store", dmem_addr, dmem_wdata);
                  end else begin
                     exp_st = store_q.pop_front();
                     if ({dmem_addr, dmem_wdata} !== {exp_st.addr, exp_st.data}) begin
                        failed++;
                        $display("FAIL store: got addr=0x%0h data=0x%0h, required addr=0x%0h data=0x%0h",
                                 dmem_addr, dmem_wdata, exp_st.addr, exp_st.data);
                     end
                  end
               end
            end
         end else if (chk_pc) begin
            chk_pc   = 1'b0;
            t_pc_nxt = t_pc + AW'(1);
            compared++;
            if (pc !== t_pc_nxt) begin
               failed++;
               $display("FAIL pc_after_mem: got 0x%0h, required 0x%0h", pc, t_pc_nxt);
            end
         end
      end
   end

   function automatic logic [15:0] rr(input logic [3:0] op, input logic [3:0] d, input logic [3:0] s);
      return {op, d, s, 4'h0};
   endfunction

   function automatic logic [15:0] ldi(input logic [3:0] d, input logic [7:0] imm);
      return {4'h7, d, imm};
   endfunction

   function automatic logic [15:0] br(input logic [3:0] op, input logic [7:0] imm);
      return {op, 4'h0, imm};
   endfunction

   localparam logic [15:0] HALT = 16'hE000;

   // Enter reset with an empty (all-HALT) program and clean scoreboards.
   task automatic hold_reset(input int delay);
      rst_n = 1'b0;
      dmem_delay = delay;
      fetch_chk = 1'b0;
      store_q.delete();
      fetch_q.delete();
      for (int i = 0; i < 256; i++) prog[i] = HALT;
      @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_halt(input string name);
      int n = 0;
      while (!halted && n < 500) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (!halted) begin
         failed++;
         $display("FAIL %s_halt: halted=%0b after %0d cycles, required 1", name, halted, n);
      end
      compared++;
      if (store_q.size() != 0 || fetch_q.size() != 0) begin
         failed++;
         $display("FAIL %s_pending: %0d stores and %0d fetches outstanding, required 0", name, store_q.size(), fetch_q.size());
      end
      fetch_chk = 1'b0;
   endtask

   task automatic test_reset();
      hold_reset(0);
      compared++;
      if ({pc, halted, flags, imem_req, dmem_req, dmem_we} !== {16'h0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0}) begin
         failed++;
         $display("FAIL reset_state: pc=0x%0h halted=%0b flags=%b imem_req=%0b dmem_req=%0b dmem_we=%0b, required all 0",
                  pc, halted, flags, imem_req, dmem_req, dmem_we);
      end
      release_reset();
      #1;
      compared++;
      if (imem_req !== 1'b0) begin
         failed++;
         $display("FAIL reset_idle: imem_req=%0b before first edge, required 0", imem_req);
      end
      @(posedge clk);
      #1;
      compared++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
         failed++;
         $display("FAIL reset_first_fetch: imem_req=%0b addr=0x%0h, required 1 0x0", imem_req, imem_addr);
      end
      wait_halt("reset");
   endtask

   task automatic test_alu_basic();
      hold_reset(0);
      prog[0] = ldi(1, 8'd5);
      prog[1] = ldi(2, 8'd3);
      prog[2] = rr(4'h2, 1, 2);
      for (int i = 0; i < 4; i++) fetch_q.push_back(AW'(i));
      fetch_chk = 1'b1;
      release_reset();
      wait_halt("alu_basic");
      compared++;
      if ({pc, flags, halted} !== {16'd3, 3'b000, 1'b1}) begin
         failed++;
         $display("FAIL alu_basic_end: pc=0x%0h flags=%b halted=%0b, required 0x3 000 1", pc, flags, halted);
      end

      hold_reset(0);
      prog[0] = ldi(1, 8'd5);
      prog[1] = ldi(2, 8'd3);
      prog[2] = rr(4'h2, 1, 2);
      prog[3] = rr(4'h9, 0, 1);
      store_q.push_back({16'h0000, 16'h0008});
      release_reset();
      wait_halt("alu_store");
      compared++;
      if (pc !== 16'd4) begin
         failed++;
         $display("FAIL alu_store_pc: got 0x%0h, required 0x4", pc);
      end
   endtask

   task automatic test_flags();
      hold_reset(0);
      dmem[8'h10] = 16'h7FFF;
      prog[0] = ldi(3, 8'h10);
      prog[1] = rr(4'h8, 1, 3);
      prog[2] = ldi(2, 8'h01);
      prog[3] = rr(4'h2, 1, 2);
      prog[4] = rr(4'h9, 3, 1);
      prog[5] = rr(4'h3, 2, 1);
      prog[6] = rr(4'h9, 3, 2);
      store_q.push_back({16'h0010, 16'h8000});
      store_q.push_back({16'h0010, 16'h8001});
      release_reset();
      wait_halt("flags_sign");
      compared++;
      if ({pc, flags} !== {16'd7, 3'b010}) begin
         failed++;
         $display("FAIL flags_sign: pc=0x%0h flags=%b, required 0x7 010", pc, flags);
      end

      hold_reset(0);
      prog[0] = ldi(4, 8'hFF);
      prog[1] = ldi(5, 8'h01);
      prog[2] = rr(4'h2, 4, 5);
      release_reset();
      wait_halt("flags_carry");
      compared++;
      if ({pc, flags} !== {16'd3, 3'b101}) begin
         failed++;
         $display("FAIL flags_carry: pc=0x%0h flags=%b, required 0x3 101", pc, flags);
      end

      hold_reset(0);
      prog[0]  = ldi(1, 8'h0F);
      prog[1]  = ldi(2, 8'h3C);
      prog[2]  = ldi(6, 8'h20);
      prog[3]  = rr(4'h1, 3, 1);
      prog[4]  = rr(4'h4, 3, 2);
      prog[5]  = rr(4'h9, 6, 3);
      prog[6]  = rr(4'h1, 3, 1);
      prog[7]  = rr(4'h5, 3, 2);
      prog[8]  = rr(4'h9, 6, 3);
      prog[9]  = ldi(7, 8'h80);
      prog[10] = rr(4'h9, 6, 7);
      prog[11] = rr(4'h3, 1, 0);
      prog[12] = rr(4'h1, 3, 1);
      prog[13] = rr(4'h6, 3, 2);
      prog[14] = rr(4'h9, 6, 3);
      store_q.push_back({16'h0020, 16'h000C});
      store_q.push_back({16'h0020, 16'h003F});
      store_q.push_back({16'h0020, 16'hFF80});
      store_q.push_back({16'h0020, 16'h0033});
      release_reset();
      wait_halt("logic_ops");
      compared++;
      if ({pc, flags} !== {16'd15, 3'b000}) begin
         failed++;
         $display("FAIL logic_ops: pc=0x%0h flags=%b, required 0xf 000", pc, flags);
      end
   endtask

   task automatic test_mem_wait();
      hold_reset(3);
      dmem[8'h30] = 16'hBEEF;
      prog[0] = ldi(1, 8'h12);
      prog[1] = ldi(2, 8'h5A);
      prog[2] = rr(4'h9, 1, 2);
      prog[3] = ldi(5, 8'h30);
      prog[4] = rr(4'h8, 4, 5);
      prog[5] = rr(4'h9, 1, 4);
      store_q.push_back({16'h0012, 16'h005A});
      store_q.push_back({16'h0012, 16'hBEEF});
      release_reset();
      wait_halt("mem_wait");
      compared++;
      if ({pc, dmem[8'h12]} !== {16'd6, 16'hBEEF}) begin
         failed++;
         $display("FAIL mem_wait_end: pc=0x%0h mem[0x12]=0x%0h, required 0x6 0xbeef", pc, dmem[8'h12]);
      end
   endtask

   task automatic test_branch();
      logic [AW-1:0] seq [12] = '{0, 1, 2, 5, 4, 8, 9, 10, 11, 12, 13, 15};
      int n;
      hold_reset(0);
      prog[0]  = ldi(1, 8'd7);
      prog[1]  = rr(4'h3, 1, 1);
      prog[2]  = br(4'hC, 8'h02);
      prog[4]  = br(4'hC, 8'h03);
      prog[5]  = br(4'hA, 8'hFE);
      prog[8]  = ldi(2, 8'd1);
      prog[9]  = rr(4'h2, 2, 0);
      prog[10] = br(4'hA, 8'hFE);
      prog[11] = br(4'hB, 8'h01);
      prog[12] = rr(4'h3, 0, 2);
      prog[13] = br(4'hB, 8'h01);
      foreach (seq[i]) fetch_q.push_back(seq[i]);
      fetch_chk = 1'b1;
      release_reset();
      wait_halt("branch");
      compared++;
      if ({pc, flags} !== {16'd15, 3'b010}) begin
         failed++;
         $display("FAIL branch_end: pc=0x%0h flags=%b, required 0xf 010", pc, flags);
      end

      hold_reset(0);
      prog[0] = br(4'hC, 8'h80);
      fetch_q.push_back(16'h0000);
      fetch_q.push_back(16'hFF81);
      fetch_chk = 1'b1;
      release_reset();
      wait_halt("jmp_wrap");
      compared++;
      if (pc !== 16'hFF81) begin
         failed++;
         $display("FAIL jmp_wrap: pc=0x%0h, required 0xff81", pc);
      end

      hold_reset(0);
      prog[0] = br(4'hC, 8'hFF);
      for (int i = 0; i < 3; i++) fetch_q.push_back(16'h0000);
      fetch_chk = 1'b1;
      release_reset();
      n = 0;
      while (fetch_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      fetch_chk = 1'b0;
      compared++;
      if (fetch_q.size() != 0 || pc !== 16'h0000 || halted !== 1'b0) begin
         failed++;
         $display("FAIL jmp_self: %0d fetches outstanding pc=0x%0h halted=%0b, required 0 0x0 0", fetch_q.size(), pc, halted);
      end
   endtask

   task automatic test_jal();
      logic [AW-1:0] exp_pc;
      hold_reset(0);
      prog[0] = ldi(15, 8'h55);
      prog[1] = ldi(6, 8'h40);
      prog[2] = br(4'hD, 8'h04);
      prog[3] = rr(4'h9, 6, 15);
      prog[7] = rr(4'h9, 6, 15);
`ifdef CORE_JAL_EN
      store_q.push_back({16'h0040, 16'h0003});
      exp_pc = 16'd8;
      fetch_q.push_back(0); fetch_q.push_back(1); fetch_q.push_back(2);
      fetch_q.push_back(7); fetch_q.push_back(8);
`else
      store_q.push_back({16'h0040, 16'h0055});
      exp_pc = 16'd4;
      for (int i = 0; i < 5; i++) fetch_q.push_back(AW'(i));
`endif
      fetch_chk = 1'b1;
      release_reset();
      wait_halt("jal");
      compared++;
      if (pc !== exp_pc) begin
         failed++;
         $display("FAIL jal_pc: got 0x%0h, required 0x%0h", pc, exp_pc);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      hold_reset(20);
      prog[0] = ldi(1, 8'hFF);
      prog[1] = ldi(2, 8'h01);
      prog[2] = rr(4'h2, 1, 2);
      prog[3] = ldi(1, 8'h09);
      prog[4] = ldi(2, 8'h50);
      prog[5] = rr(4'h9, 2, 1);
      release_reset();
      while (!dmem_req && n < 50) begin
         @(negedge clk);
         n++;
      end
      compared++;
      if (!dmem_req) begin
         failed++;
         $display("FAIL reset_mid_wait: dmem_req=%0b after %0d cycles, required 1", dmem_req, n);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      compared++;
      if ({dmem_req, dmem_we, imem_req, pc, flags, halted} !== {1'b0, 1'b0, 1'b0, 16'h0, 3'b000, 1'b0}) begin
         failed++;
         $display("FAIL reset_mid_drop: dmem_req=%0b dmem_we=%0b imem_req=%0b pc=0x%0h flags=%b halted=%0b, required all 0",
                  dmem_req, dmem_we, imem_req, pc, flags, halted);
      end
      hold_reset(0);
      prog[0] = rr(4'h9, 1, 2);
      store_q.push_back({16'h0000, 16'h0000});
      fetch_q.push_back(16'h0000);
      fetch_q.push_back(16'h0001);
      fetch_chk = 1'b1;
      release_reset();
      wait_halt("reset_mid");
      compared++;
      if (pc !== 16'd1) begin
         failed++;
         $display("FAIL reset_mid_pc: got 0x%0h, required 0x1", pc);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      for (int i = 0; i < 256; i++) dmem[i] = '0;
      test_reset();
      test_alu_basic();
      test_flags();
      test_mem_wait();
      test_branch();
      test_jal();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 SHALL have parameter DW, default 16, meaning datapath/register width (legal 8..32).
REQ-002 SHALL have parameter AW, default 16, meaning instruction/data word-address width (legal 4..DW).
REQ-003 SHALL have parameter NREG, default 16, meaning register count (8 or 16); register index = low log2(NREG) bits of the instruction field.
REQ-004 SHALL have ports: clk in 1 clock; rst_n in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: imem_req out 1 fetch request; imem_addr out AW fetch address; imem_ack in 1 fetch complete; imem_rdata in 16 instruction word.
REQ-006 SHALL have ports: dmem_req out 1 data request; dmem_we out 1 write strobe; dmem_addr out AW; dmem_wdata out DW; dmem_ack in 1 complete; dmem_rdata in DW.
REQ-007 SHALL have ports: pc out AW current PC; halted out 1 core stopped; flags out 3 {C,N,Z}.

Function
REQ-008 SHALL decode instruction fields as op=[15:12], dst=[11:8], src=[7:4], imm8=[7:0]; sext(imm8) = imm8 sign-extended to DW or AW.
REQ-009 SHALL implement opcodes: 0 NOP; 1 MOV dst<=src; 2 ADD; 3 SUB; 4 AND; 5 OR; 6 XOR (dst<=dst op src); 7 LDI dst<=sext(imm8); 8 LD dst<=mem[src]; 9 ST mem[dst]<=src; A BZ; B BN; C JMP; D JAL; E HALT; F treated as NOP.
REQ-010 SHALL use FSM states FETCH, EXEC, MEM, HALT; reset state FETCH.
REQ-011 FETCH: imem_req=1, imem_addr=pc; on imem_ack=1, latch imem_rdata and go to EXEC; same-cycle ack accepted.
REQ-012 EXEC (one cycle): ALU/MOV/LDI write register; branches/jumps update pc; LD/ST go to MEM; HALT goes to HALT; all others return to FETCH.
REQ-013 Non-jump instructions SHALL set pc <= pc+1 on leaving EXEC (LD/ST: on leaving MEM); arithmetic modulo 2^AW.
REQ-014 BZ/BN taken (Z=1 / N=1) and JMP SHALL set pc <= pc+1+sext(imm8) modulo 2^AW; a not-taken branch sets pc <= pc+1.
REQ-015 MEM: dmem_req=1, dmem_addr=low AW bits of address register, dmem_we=1 for ST only, dmem_wdata=src register; outputs SHALL hold stable until dmem_ack; on ack LD writes dmem_rdata to dst, then FETCH.
REQ-016 ADD/SUB/AND/OR/XOR SHALL update flags: Z = result==0; N = result[DW-1]; C = carry-out (ADD), 1 when dst>=src unsigned (SUB), 0 (logic ops); all other ops SHALL leave flags unchanged.
REQ-017 Register writes SHALL occur at the clock edge leaving EXEC/MEM; a read in the next EXEC SHALL see the new value.
REQ-018 HALT: imem_req=dmem_req=0, halted=1, pc frozen; SHALL persist until rst_n low.
REQ-019 imem_req and dmem_req SHALL never be high in the same cycle.

Reset
REQ-020 rst_n low SHALL asynchronously force: state=FETCH, pc=0, flags=0, all registers=0, imem_req=0, dmem_req=0, dmem_we=0, halted=0.
REQ-021 Reset asserted mid-transaction SHALL drop requests immediately; any pending ack SHALL be ignored; the first FETCH of address 0 begins on the first clock edge after rst_n deasserts.

Configuration
REQ-022 Macro CORE_JAL_EN defined: opcode D (JAL) SHALL write pc+1 (zero-extended to DW) to register NREG-1 and set pc <= pc+1+sext(imm8).
REQ-023 Macro CORE_JAL_EN undefined: opcode D SHALL behave as NOP (no register write, pc <= pc+1).

Structure
REQ-024 Opcode constants, FSM state encoding and the flags struct SHALL live in shared package core_pkg.
REQ-025 The ALU (opcode, A, B -> result, C, N, Z; width DW) SHALL be a separate sub-module core_alu; register file, FSM and PC remain in multicycle_core.

Verification
REQ-026 Reset then program LDI R1,5; LDI R2,3; ADD R1,R2; HALT with imem_ack always 1 -> R1=8, flags Z=0 N=0 C=0, halted=1 with pc=3.
REQ-027 LDI R1,0x7F (DW=8), LDI R2,0x01, ADD R1,R2 -> R1=0x80, N=1, C=0; then SUB R2,R1 (1-0x80) -> C=0, N=1.
REQ-028 ST then LD with dmem_ack delayed 3 cycles -> dmem_req/addr/wdata stable 4 cycles; LD writes rdata 0xBEEF (DW=16); pc advances only after ack.
REQ-029 SUB R1,R1 then BZ -2 at pc=5 -> next fetch address 4; BZ with Z=0 -> next fetch address 6; JMP -1 at pc=0 with AW=4 -> pc=0 (wrap check with imm 0xFF from pc=0 -> pc=0).
REQ-030 rst_n pulsed low while dmem_req high -> dmem_req=0 within the same cycle; next fetch at address 0; registers cleared.
REQ-031 JAL +4 at pc=2 with CORE_JAL_EN -> R15=3, pc=7; without macro -> R15 unchanged, pc=3.
